// File: rtl/prbs_checker_if.sv
// Word stream and lock/error status bundle for prbs_checker.
interface prbs_checker_if #(
  parameter int LENGTH = 4,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [LENGTH-1:0] in_data;
  logic              clr_count;
  logic              locked;
  logic              err_pulse;
  logic              lock_lost;
  logic [CNT_W-1:0]  err_count;
  logic [LENGTH-1:0] exp_data;

  modport master (
    output in_valid, in_data, clr_count,
    input  locked, err_pulse, lock_lost, err_count, exp_data
  );

  modport slave (
    input  in_valid, in_data, clr_count,
    output locked, err_pulse, lock_lost, err_count, exp_data
  );
endinterface

// File: rtl/prbs_checker.sv
// PRBS word checker: hunts for a seed, confirms LOCK_CNT successive LFSR steps,
// then free-runs its reference and counts mismatching words until lock is lost.
module prbs_checker #(
  parameter int LENGTH   = 4,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  prbs_checker_if.slave  bus
);

  localparam bit LEGAL = (LENGTH == 2) || (LENGTH == 3) || (LENGTH == 4) ||
                         (LENGTH == 8) || (LENGTH == 16);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_CNT);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t             r_state, w_nextState;
  logic [LENGTH-1:0]  r_ref, w_nextRef, w_stepRef;
  logic [MATCH_W-1:0] r_matchCnt, w_nextMatch, w_matchInc;
  logic [MISS_W-1:0]  r_missCnt, w_nextMiss, w_missInc;
  logic               w_fb, w_wordOk, w_dataZero, w_errHit, w_lost;
  logic               r_locked, r_errPulse, r_lockLost;
  logic [CNT_W-1:0]   r_errCount;

  // Feedback taps of the generator; unsupported widths leave the block inert.
  generate
    if (LENGTH == 2)       begin : gFb assign w_fb = r_ref[0] ^ r_ref[1]; end
    else if (LENGTH == 3)  begin : gFb assign w_fb = r_ref[0] ^ r_ref[2]; end
    else if (LENGTH == 4)  begin : gFb assign w_fb = r_ref[0] ^ r_ref[3]; end
    else if (LENGTH == 8)  begin : gFb assign w_fb = r_ref[0] ^ r_ref[2] ^ r_ref[3] ^ r_ref[4]; end
    else if (LENGTH == 16) begin : gFb assign w_fb = r_ref[0] ^ r_ref[2] ^ r_ref[3] ^ r_ref[5]; end
    else                   begin : gFb assign w_fb = 1'b0; end
  endgenerate

  assign w_stepRef  = {w_fb, r_ref[LENGTH-1:1]};
  assign w_wordOk   = (bus.in_data == w_stepRef);
  assign w_dataZero = (bus.in_data == '0);
  assign w_matchInc = r_matchCnt + 1'b1;
  assign w_missInc  = r_missCnt + 1'b1;

  always_comb begin
    w_nextState = r_state;
    w_nextRef   = r_ref;
    w_nextMatch = r_matchCnt;
    w_nextMiss  = r_missCnt;
    w_errHit    = 1'b0;
    w_lost      = 1'b0;
    if (bus.in_valid) begin
      case (r_state)
        HUNT: begin
          if (!w_dataZero) begin
            w_nextRef   = bus.in_data;
            w_nextMatch = '0;
            w_nextState = SYNC;
          end
        end
        SYNC: begin
          if (w_dataZero) begin
            w_nextState = HUNT;
          end else if (w_wordOk) begin
            w_nextRef   = bus.in_data;
            w_nextMatch = w_matchInc;
            if (w_matchInc == LOCK_LAST) begin
              w_nextState = LOCKED;
              w_nextMiss  = '0;
            end
          end else begin
            w_nextRef   = bus.in_data;
            w_nextMatch = '0;
          end
        end
        LOCKED: begin
          // Reference free-runs so a single flipped bit costs exactly one mismatch.
          w_nextRef = w_stepRef;
          if (w_wordOk) begin
            w_nextMiss = '0;
          end else begin
            w_errHit   = 1'b1;
            w_nextMiss = w_missInc;
            if (w_missInc == LOSS_LAST) begin
              w_nextState = HUNT;
              w_lost      = 1'b1;
            end
          end
        end
        default: w_nextState = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !LEGAL) begin
      r_state    <= HUNT;
      r_ref      <= '0;
      r_matchCnt <= '0;
      r_missCnt  <= '0;
      r_locked   <= 1'b0;
      r_errPulse <= 1'b0;
      r_lockLost <= 1'b0;
      r_errCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_ref      <= w_nextRef;
      r_matchCnt <= w_nextMatch;
      r_missCnt  <= w_nextMiss;
      r_locked   <= (w_nextState == LOCKED);
      r_errPulse <= w_errHit;
      r_lockLost <= w_lost;
      if (bus.clr_count) begin
        r_errCount <= '0;
      end else if (w_errHit && (r_errCount != '1)) begin
        r_errCount <= r_errCount + 1'b1;
      end
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_errPulse;
  assign bus.lock_lost = r_lockLost;
  assign bus.err_count = r_errCount;
  assign bus.exp_data  = r_ref;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: LENGTH=4 main instance, a CNT_W=4 instance
// for saturation and an unsupported-LENGTH instance that must stay silent.
module tb_prbs_checker;

  typedef struct packed {
    logic        locked;
    logic        errPulse;
    logic        lockLost;
    logic [15:0] errCount;
    logic [3:0]  expData;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  logic [3:0] refModel = 4'h0;
  int   cntModel = 0;
  logic [3:0] lockSeq [5] = '{4'hF, 4'h7, 4'hB, 4'h5, 4'hA};

  always #5 clk = ~clk;

  prbs_checker_if #(.LENGTH(4), .CNT_W(16)) bus ();
  prbs_checker_if #(.LENGTH(4), .CNT_W(4))  busSat ();
  prbs_checker_if #(.LENGTH(5), .CNT_W(16)) busBad ();

  prbs_checker #(.LENGTH(4), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  prbs_checker #(.LENGTH(4), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .bus(busSat.slave));
  prbs_checker #(.LENGTH(5), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dutBad (
    .clk(clk), .rst(rst), .bus(busBad.slave));

  // Independent model of the 4-bit generator: x^4 + x^3 + 1, shifting right.
  function automatic logic [3:0] lfsrStep(input logic [3:0] w);
    return {w[0] ^ w[3], w[3:1]};
  endfunction

  function automatic obs_t mkExp(input logic l, input logic p, input logic ll,
                                 input int c, input logic [3:0] d);
    obs_t e;
    e.locked = l; e.errPulse = p; e.lockLost = ll; e.errCount = 16'(c); e.expData = d;
    return e;
  endfunction

  function automatic obs_t sampleMain();
    obs_t s;
    s.locked = bus.locked; s.errPulse = bus.err_pulse; s.lockLost = bus.lock_lost;
    s.errCount = bus.err_count; s.expData = bus.exp_data;
    return s;
  endfunction

  task automatic driveCycle(input logic r, input logic v, input logic [3:0] d, input logic clr);
    rst = r;
    bus.in_valid = v;    bus.in_data = d;    bus.clr_count = clr;
    busSat.in_valid = v; busSat.in_data = d; busSat.clr_count = clr;
    busBad.in_valid = v; busBad.in_data = {1'b1, d}; busBad.clr_count = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mkExp(0, 0, 0, 0, 4'h0));
      driveCycle(1, 1, 4'hF, 0);
      got = sampleMain(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL reset[%0d]: got %p, required %p", i, got, want);
      end
    end
  endtask

  task automatic test_lock();
    obs_t got, want;
    for (int i = 0; i < 5; i++) begin
      refModel = lockSeq[i];
      sb.push_back(mkExp(i == 4, 0, 0, cntModel, refModel));
      driveCycle(0, 1, lockSeq[i], 0);
      got = sampleMain(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL lock[%0d]: got %p, required %p", i, got, want);
      end
    end
  endtask

  task automatic test_single_error();
    obs_t got, want;
    logic [3:0] word;
    logic v;
    for (int i = 0; i < 5; i++) begin
      v = (i < 4);
      if (v) refModel = lfsrStep(refModel);
      word = (i == 0) ? (refModel ^ 4'b0001) : refModel;
      if (i == 0) cntModel++;
      sb.push_back(mkExp(1, i == 0, 0, cntModel, refModel));
      driveCycle(0, v, word, 0);
      got = sampleMain(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL single_err[%0d]: got %p, required %p", i, got, want);
      end
    end
  endtask

  task automatic test_loss();
    obs_t got, want;
    logic [3:0] word;
    logic v, clr, l, p, ll;
    for (int i = 0; i < 10; i++) begin
      v = 1; clr = 0; l = 0; p = 0; ll = 0; word = 4'h0;
      if (i == 0) begin
        v = 0; clr = 1; l = 1; cntModel = 0;
      end else if (i <= 3) begin
        refModel = lfsrStep(refModel);
        word = refModel ^ 4'b1000;
        cntModel++;
        p = 1; l = (i < 3); ll = (i == 3);
      end else if (i == 4) begin
        v = 0;
      end else begin
        refModel = lockSeq[i-5];
        word = refModel;
        l = (i == 9);
      end
      sb.push_back(mkExp(l, p, ll, cntModel, refModel));
      driveCycle(0, v, word, clr);
      got = sampleMain(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL loss[%0d]: got %p, required %p", i, got, want);
      end
    end
  endtask

  task automatic test_zero_idle();
    obs_t got, want;
    logic       vTab [13];
    logic [3:0] dTab [13];
    logic [3:0] eTab [13];
    vTab = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1};
    dTab = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h7, 4'hF, 4'hB, 4'hF, 4'hF, 4'h5, 4'hA, 4'hF, 4'hD};
    eTab = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h7, 4'h7, 4'hB, 4'hB, 4'hB, 4'h5, 4'hA, 4'hA, 4'hD};
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        refModel = 4'h0; cntModel = 0;
        sb.push_back(mkExp(0, 0, 0, 0, 4'h0));
        driveCycle(1, 0, 4'h0, 0);
      end else begin
        refModel = eTab[i-1];
        sb.push_back(mkExp(i == 13, 0, 0, cntModel, refModel));
        driveCycle(0, vTab[i-1], dTab[i-1], 0);
      end
      got = sampleMain(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL zero_idle[%0d]: got %p, required %p", i, got, want);
      end
    end
  endtask

  task automatic test_sync_resync();
    obs_t got, want;
    logic [3:0] word;
    logic r;
    for (int i = 0; i < 8; i++) begin
      r = (i == 0);
      case (i)
        0:       begin refModel = 4'h0; cntModel = 0; word = 4'hF; end
        1:       begin refModel = 4'hF; word = refModel; end
        2:       begin refModel = 4'h7; word = refModel; end
        3:       begin refModel = 4'h6; word = refModel; end
        default: begin refModel = lfsrStep(refModel); word = refModel; end
      endcase
      sb.push_back(mkExp(i == 7, 0, 0, cntModel, refModel));
      driveCycle(r, 1, word, 0);
      got = sampleMain(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL sync_resync[%0d]: got %p, required %p", i, got, want);
      end
    end
  endtask

  task automatic test_saturation();
    obs_t got, want;
    logic [3:0] word;
    logic r, clr, wrong;
    int satCnt = 0;
    for (int i = 0; i < 47; i++) begin
      r = 0; clr = 0; wrong = 0;
      if (i == 0) begin
        r = 1; refModel = 4'h0; cntModel = 0; satCnt = 0; word = 4'hF;
      end else if (i <= 5) begin
        refModel = lockSeq[i-1]; word = refModel;
      end else begin
        refModel = lfsrStep(refModel);
        wrong = ((i - 6) % 2 == 0);
        clr = (i == 46);
        word = wrong ? (refModel ^ 4'b0100) : refModel;
      end
      if (clr) begin
        cntModel = 0; satCnt = 0;
      end else if (wrong) begin
        cntModel++;
        if (satCnt < 15) satCnt++;
      end
      sb.push_back(mkExp(i >= 5, wrong, 0, cntModel, refModel));
      driveCycle(r, 1, word, clr);
      got = sampleMain(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL sat_main[%0d]: got %p, required %p", i, got, want);
      end
      checks++;
      if ({busSat.err_count, busSat.err_pulse} !== {4'(satCnt), wrong}) begin
        errors++;
        $display("[TB] FAIL sat_cnt4[%0d]: got cnt=%0d pulse=%b, required cnt=%0d pulse=%b",
                 i, busSat.err_count, busSat.err_pulse, satCnt, wrong);
      end
    end
  endtask

  task automatic test_reset_midlock();
    obs_t got, want;
    logic [3:0] word;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        word = lfsrStep(refModel);
        refModel = 4'h0; cntModel = 0;
        sb.push_back(mkExp(0, 0, 0, 0, 4'h0));
        driveCycle(1, 1, word, 0);
      end else begin
        refModel = lockSeq[i-1];
        sb.push_back(mkExp(i == 5, 0, 0, cntModel, refModel));
        driveCycle(0, 1, refModel, 0);
      end
      got = sampleMain(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL reset_midlock[%0d]: got %p, required %p", i, got, want);
      end
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 5; i++) begin
      driveCycle(0, 1, lockSeq[i], 0);
      checks++;
      if ({busBad.locked, busBad.err_pulse, busBad.lock_lost, busBad.err_count, busBad.exp_data} !== '0) begin
        errors++;
        $display("[TB] FAIL illegal_len[%0d]: got locked=%b cnt=%0d exp=%h, required all zero",
                 i, busBad.locked, busBad.err_count, busBad.exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_zero_idle();
    test_sync_resync();
    test_saturation();
    test_reset_midlock();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 The block SHALL have parameter LENGTH, default 4, giving the word and LFSR width; legal values are 2, 3, 4, 8 and 16.
REQ-002 The block SHALL have parameter LOCK_CNT, default 4, giving the number of consecutive matching words needed to declare lock.
REQ-003 The block SHALL have parameter LOSS_CNT, default 3, giving the number of consecutive mismatching words while locked that declares loss of lock.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the error counter width.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  in_data holds a word this cycle.
REQ-008 in_data  input  LENGTH  received word, formatted as the LFSR generator's parallel output.
REQ-009 clr_count  input  1  synchronous clear of err_count.
REQ-010 locked  output  1  checker is in LOCKED state.
REQ-011 err_pulse  output  1  one-cycle pulse per mismatching word while LOCKED.
REQ-012 lock_lost  output  1  one-cycle pulse on the LOCKED to HUNT transition.
REQ-013 err_count  output  CNT_W  saturating count of mismatching words while LOCKED.
REQ-014 exp_data  output  LENGTH  current reference word, from which the next expected word is computed.

Function
REQ-015 step(w) SHALL be {fb, w[LENGTH-1:1]}, with fb defined per LENGTH as follows:
- LENGTH 2: fb = w0^w1.
- LENGTH 3: fb = w0^w2.
- LENGTH 4: fb = w0^w3.
- LENGTH 8: fb = w0^w2^w3^w4.
- LENGTH 16: fb = w0^w2^w3^w5.
REQ-016 For any other LENGTH, the block SHALL hold all outputs at 0 permanently.
REQ-017 The FSM SHALL have three states: HUNT, SYNC and LOCKED.
REQ-018 A cycle with in_valid=0 SHALL change no state, counter or reference, and SHALL produce no pulses.
REQ-019 In HUNT, on a valid nonzero word: ref <= in_data, match_cnt <= 0, go to SYNC.
REQ-020 In HUNT, an all-zero valid word SHALL be ignored.
REQ-021 In SYNC, on a valid word equal to step(ref): ref <= in_data and match_cnt increments.
REQ-022 In SYNC, when the incremented match_cnt equals LOCK_CNT, the FSM SHALL go to LOCKED and set miss_cnt <= 0.
REQ-023 In SYNC, on a valid nonzero mismatching word: ref <= in_data (self-resync), match_cnt <= 0, stay in SYNC.
REQ-024 In SYNC, on a valid all-zero word: go to HUNT.
REQ-025 In LOCKED, every valid word SHALL advance the reference free-running, ref <= step(ref), regardless of in_data, so one bit error produces exactly one mismatch.
REQ-026 In LOCKED, on a valid word equal to step(ref): miss_cnt <= 0.
REQ-027 In LOCKED, on a valid mismatching word:
- err_pulse=1 the next cycle.
- err_count increments, saturating at all-ones.
- miss_cnt increments.
REQ-028 When the incremented miss_cnt reaches LOSS_CNT, the FSM SHALL go to HUNT and lock_lost=1 for one cycle; locked drops in that same cycle.
REQ-029 Error counting SHALL occur only in LOCKED; mismatches in HUNT and SYNC SHALL never touch err_count or err_pulse.
REQ-030 When clr_count coincides with an increment, the clear SHALL win: err_count=0, while err_pulse still asserts.
REQ-031 All outputs SHALL be registered, with one cycle of latency from the accepted word to the output update.
REQ-032 exp_data SHALL equal ref.
REQ-033 match_cnt and miss_cnt SHALL be sized to hold LOCK_CNT and LOSS_CNT respectively.

Reset
REQ-034 While rst=1 at a clock edge, the block SHALL set:
- state to HUNT;
- ref, match_cnt and miss_cnt to 0;
- locked, err_pulse, lock_lost, err_count and exp_data to 0.
REQ-035 A reset asserted mid-operation SHALL discard lock immediately at the next edge; in_valid SHALL be ignored during reset.
REQ-036 err_count SHALL be preserved across loss of lock; only rst and clr_count clear it.

Verification (LENGTH=4 and defaults unless stated)
REQ-037 The bench SHALL cover lock acquisition:
- Stimulus: valid words 1111, 0111, 1011, 0101, 1010 on consecutive cycles.
- Response: locked=1 in the cycle after 1010 is accepted; err_count=0.
REQ-038 The bench SHALL cover a single bit error:
- Stimulus: when locked, expected 1101 sent as 1100, then a correct stream continues (0110, 0011, ...).
- Response: exactly one err_pulse; err_count=1; locked stays 1.
REQ-039 The bench SHALL cover loss of lock:
- Stimulus: when locked, three consecutive wrong words.
- Response: err_count=3; lock_lost pulses once with locked falling to 0 in the same cycle; state HUNT.
- Follow-up: a fresh valid sequence relocks; err_count stays at 3.
REQ-040 The bench SHALL cover zero-word and idle behaviour:
- Stimulus: all-zero words in HUNT, then in_valid=0 gaps inserted within a lock sequence.
- Response: zero words are ignored; the gaps neither break nor delay lock beyond the valid-word count.
REQ-041 The bench SHALL cover saturation and clear:
- Stimulus: CNT_W=4, locked, 20 mismatches with a correct word every second word.
- Response: err_count holds at 1111.
- Follow-up: clr_count coinciding with a further error gives err_count=0 and err_pulse=1.
REQ-042 The bench SHALL cover reset mid-lock:
- Stimulus: rst=1 for one cycle while locked.
- Response: all outputs 0 at the next edge; relock requires 1+LOCK_CNT valid words.
